// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative radix-2 restoring divider for DIV / DIVU
//
// Sits in the execute stage beside the ALU. One quotient bit is produced per
// cycle, MSB first, over WIDTH cycles. Signed operands are reduced to
// magnitudes before iterating, and the signs are re-applied when the result is
// produced. Upstream stages are held through stall while the divide runs.
//
// Sequence: IDLE -> PREP -> CALC (x WIDTH) -> DONE -> IDLE
//   go at cycle 0, ready at cycle WIDTH+2.
//
// Optional feature (compile-time macro DIV_ZERO_FAST_EN):
//   a zero divisor seen on go jumps straight from IDLE to DONE, so ready
//   arrives at cycle 1. The result values are the same as in the default build.
//
// Ports
//   clk        in   1      pipeline clock, rising edge
//   resetn     in   1      asynchronous, active-low reset
//   alucontrol in   8      decoded op; only DIV_OP / DIVU_OP start a divide
//   start      in   1      E-stage instruction valid (not bubbled)
//   annul      in   1      E-stage flush; aborts any divide in flight
//   a          in   WIDTH  dividend (rs)
//   b          in   WIDTH  divisor (rt)
//   stall      out  1      hold upstream stages while dividing
//   ready      out  1      one-cycle pulse; hi/lo carry the new result
//   hi         out  WIDTH  remainder
//   lo         out  WIDTH  quotient
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [7:0] DIV_OP  = 8'b0001_1010,
  parameter logic [7:0] DIVU_OP = 8'b0001_1011
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrol,
  input  logic             start,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;         // dividend as latched; also the div-by-zero remainder
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic             r_b_zero;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_dvd;       // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] r_dvs;       // divisor magnitude
  logic [WIDTH:0]   r_rem;       // partial remainder, one guard bit wide
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_div;
  logic             w_go;
  logic             w_fast_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_lo_res;
  logic [WIDTH-1:0] w_hi_res;

  assign w_is_div = (alucontrol == DIV_OP) || (alucontrol == DIVU_OP);
  // annul outranks start, so a flushed instruction never launches a divide.
  assign w_go     = (r_state == S_IDLE) && start && !annul && w_is_div;

`ifdef DIV_ZERO_FAST_EN
  assign w_fast_zero = (b == '0);
`else
  assign w_fast_zero = 1'b0;
`endif

  // Magnitudes are formed from the latched operands; 0x80..0 maps onto itself,
  // which is still the correct unsigned magnitude.
  assign w_abs_a = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH];

  // Sign fix-up. A zero divisor bypasses it: the quotient is all ones and the
  // remainder is the raw dividend, whatever the operand signs.
  assign w_q_fix  = r_neg_q ? -r_dvd : r_dvd;
  assign w_r_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  assign w_lo_res = r_b_zero ? '1  : w_q_fix;
  assign w_hi_res = r_b_zero ? r_a : w_r_fix;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: w_next takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = w_fast_zero ? S_DONE : S_PREP;
      S_PREP: w_next = annul ? S_IDLE : S_CALC;
      S_CALC: begin
        if (annul)                             w_next = S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))   w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The result is shown combinationally in DONE and captured at the end of it,
  // so annul in DONE hides it and leaves the held values untouched.
  assign stall = w_go || (r_state == S_PREP) || (r_state == S_CALC);
  assign ready = (r_state == S_DONE) && !annul;
  assign hi    = ready ? w_hi_res : r_hi;
  assign lo    = ready ? w_lo_res : r_lo;

  // NOTE: datapath registers are reset too, because hi/lo are architecturally
  // visible as zero after reset and the rest must never leak X into them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_b_zero <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= (alucontrol == DIV_OP);
            r_b_zero <= (b == '0);
          end
        end
        S_PREP: begin
          r_dvd   <= w_abs_a;
          r_dvs   <= w_abs_b;
          r_neg_q <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= r_signed && r_a[WIDTH-1];
          r_rem   <= '0;
          r_cnt   <= '0;
        end
        S_CALC: begin
          r_rem <= w_qbit ? w_diff : w_shift;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          if (ready) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed bench for div_unit
//
// Expected quotient/remainder pairs are queued when a divide is launched and
// popped when ready pulses. Also covers latency, stall shape, annul in CALC
// and DONE, start+annul, non-divide ops and asynchronous reset mid-divide.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int         W       = 32;
  localparam logic [7:0] DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] DIVU_OP = 8'b0001_1011;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } result_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic [7:0]   alucontrol;
  logic         start;
  logic         annul;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         ready;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int      checks = 0;
  int      errors = 0;
  result_t sb_q[$];
  result_t last;

  div_unit #(
    .WIDTH  (W),
    .DIV_OP (DIV_OP),
    .DIVU_OP(DIVU_OP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .alucontrol(alucontrol),
    .start     (start),
    .annul     (annul),
    .a         (a),
    .b         (b),
    .stall     (stall),
    .ready     (ready),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from SystemVerilog arithmetic (truncating division,
  // remainder carries the dividend sign) plus the two architectural corners.
  function automatic result_t model(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    result_t r;
    if (y == '0) begin
      r.lo = '1;
      r.hi = x;
    end else if (op == DIV_OP) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        r.lo = 32'h8000_0000;
        r.hi = '0;
      end else begin
        r.lo = $signed(x) / $signed(y);
        r.hi = $signed(x) % $signed(y);
      end
    end else begin
      r.lo = x / y;
      r.hi = x % y;
    end
    return r;
  endfunction

  task automatic push_exp(input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    result_t r;
    r.lo = exp_lo;
    r.hi = exp_hi;
    sb_q.push_back(r);
  endtask

  task automatic launch(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    alucontrol = op;
    a          = x;
    b          = y;
    start      = 1'b1;
  endtask

  task automatic release_inputs();
    start      = 1'b0;
    alucontrol = 8'h00;
    a          = $urandom;
    b          = $urandom;
  endtask

  // Launch a divide, follow it to ready and compare against the queue head.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int      lat;
    int      exp_lat;
    int      stall_gaps;
    bit      seen;
    result_t e;
`ifdef DIV_ZERO_FAST_EN
    exp_lat = (y == '0) ? 1 : W + 2;
`else
    exp_lat = W + 2;
`endif
    launch(op, x, y);
    @(negedge clk);
    check({tag, "_stall_go"}, stall, 1);
    @(posedge clk); #1;
    release_inputs();
    lat        = 0;
    stall_gaps = 0;
    seen       = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        lat  = c;
      end else if (!stall) begin
        stall_gaps++;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_gaps"}, stall_gaps, 0);
    e = sb_q.pop_front();
    if (seen) begin
      check({tag, "_stall_done"}, stall, 0);
      check({tag, "_lo"}, lo, e.lo);
      check({tag, "_hi"}, hi, e.hi);
      @(negedge clk);
      check({tag, "_ready_pulse"}, ready, 0);
      check({tag, "_lo_hold"}, lo, e.lo);
      check({tag, "_hi_hold"}, hi, e.hi);
      last = e;
    end
  endtask

  // Watch for n cycles and confirm ready never pulses.
  task automatic expect_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check({tag, "_no_ready"}, pulses, 0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [7:0]   rop;

    resetn     = 1'b0;
    alucontrol = 8'h00;
    start      = 1'b0;
    annul      = 1'b0;
    a          = '0;
    b          = '0;
    last.lo    = '0;
    last.hi    = '0;

    #3;
    check("rst_stall", stall, 0);
    check("rst_ready", ready, 0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    @(negedge clk);
    resetn = 1'b1;

    push_exp(32'd3, 32'd1);
    run_div("s7_2", DIV_OP, 32'd7, 32'd2);
    push_exp(32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("sm7_2", DIV_OP, -32'sd7, 32'd2);
    push_exp(32'h8000_0000, 32'h0);
    run_div("s_ovf", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
    push_exp(32'h0FFF_FFFF, 32'hF);
    run_div("u_big", DIVU_OP, 32'hFFFF_FFFF, 32'h10);
    push_exp(32'h0, 32'hFFFF_FFFF);
    run_div("s_big", DIV_OP, 32'hFFFF_FFFF, 32'h10);
    push_exp(32'hFFFF_FFFF, 32'h1234);
    run_div("z_pos", DIV_OP, 32'h1234, 32'h0);
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_div("z_neg", DIV_OP, 32'hFFFF_FFF9, 32'h0);
    push_exp(32'hFFFF_FFFF, 32'h8765_4321);
    run_div("z_u", DIVU_OP, 32'h8765_4321, 32'h0);

    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = $urandom_range(1, 5000);
      rb  = (i % 2 == 1) ? -rb : rb;
      rop = (i < 2) ? DIV_OP : DIVU_OP;
      sb_q.push_back(model(rop, ra, rb));
      run_div("rand", rop, ra, rb);
    end

    // annul in CALC at cycle 10: idle at 11, no result, held values kept.
    launch(DIV_OP, 32'd100, 32'd3);
    @(posedge clk); #1;
    release_inputs();
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    check("annul_stall_c10", stall, 1);
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul_idle_c11", stall, 0);
    expect_quiet("annul_calc", 40);
    check("annul_lo_keep", lo, last.lo);
    check("annul_hi_keep", hi, last.hi);
    push_exp(32'd33, 32'd1);
    run_div("s100_3", DIV_OP, 32'd100, 32'd3);

    // annul in DONE at cycle 34: the result never appears.
    launch(DIVU_OP, 32'd50, 32'd7);
    @(posedge clk); #1;
    release_inputs();
    repeat (33) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    check("annul_done_ready", ready, 0);
    check("annul_done_lo", lo, last.lo);
    @(posedge clk); #1;
    annul = 1'b0;
    expect_quiet("annul_done", 5);
    check("annul_done_lo_keep", lo, last.lo);
    check("annul_done_hi_keep", hi, last.hi);

    // start and annul together in IDLE: no divide launched.
    launch(DIV_OP, 32'd9, 32'd4);
    annul = 1'b1;
    @(negedge clk);
    check("st_an_stall", stall, 0);
    @(posedge clk); #1;
    annul = 1'b0;
    release_inputs();
    expect_quiet("st_an", 40);

    // A non-divide op with start never stalls.
    launch(8'h20, 32'd9, 32'd4);
    @(negedge clk);
    check("nondiv_stall", stall, 0);
    @(posedge clk); #1;
    release_inputs();
    expect_quiet("nondiv", 40);

    // Asynchronous reset at cycle 20 of a divide.
    launch(DIVU_OP, 32'd1000, 32'd7);
    @(posedge clk); #1;
    release_inputs();
    repeat (19) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_hi", hi, '0);
    check("mid_rst_lo", lo, '0);
    @(negedge clk);
    resetn = 1'b1;
    expect_quiet("mid_rst", 40);
    push_exp(32'd142, 32'd6);
    run_div("after_rst", DIVU_OP, 32'd1000, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
